i2c_slave_rx: RTL and testbench
===============================

I2C_SLAVE_RX -- requirements
Module: i2c_slave_rx

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h55: 7-bit address this slave answers to.
REQ-002 Parameter NUM_BYTE, default 4: data bytes per write transaction.
REQ-003 Parameter BYTE_SIZE, default 8: bits per byte; DATA_WIDTH = NUM_BYTE*BYTE_SIZE.
REQ-004 clk  input  1  system clock, single clock domain.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 i2c_SCL  input  1  I2C clock from the bus master; the slave does no clock stretching.
REQ-007 i2c_SDA  inout  1  I2C data line; open-drain, driven only to 0, otherwise high-Z.
REQ-008 rdata  output  DATA_WIDTH  last complete write payload.
REQ-009 rdata_vld  output  1  one-cycle pulse when rdata is updated.
REQ-010 rx_err  output  1  one-cycle pulse on a malformed or overrun transaction.
REQ-011 busy  output  1  high from a detected START until STOP or error recovery.

Function
REQ-012 SCL and SDA SHALL pass through a 2-flop synchronizer; all decoding SHALL use the synchronized values.
REQ-013 START SHALL be detected as an SDA fall while SCL is high; STOP as an SDA rise while SCL is high.
REQ-014 Bits SHALL be sampled on the SCL rising edge, MSB first.
REQ-015 The SDA drive SHALL change only on an SCL falling edge.
REQ-016 FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, WAIT_STOP.
REQ-017 IDLE -> ADDR on START; ADDR collects 7 address bits plus the R/W bit.
REQ-018 Address match with R/W=0 SHALL give ADDR_ACK: SDA is driven low for the 9th SCL period, then the FSM enters DATA.
REQ-019 Address mismatch or R/W=1 SHALL release SDA (NACK) and enter WAIT_STOP; rx_err SHALL NOT pulse in this case.
REQ-020 Each byte received in DATA SHALL be ACKed in DATA_ACK while the byte count is below NUM_BYTE.
REQ-021 The first received byte SHALL map to rdata[DATA_WIDTH-1 -: BYTE_SIZE]; later bytes fill downward.
REQ-022 Data SHALL shift into an internal register; rdata SHALL update only on a valid completion.
REQ-023 Valid completion: STOP after exactly NUM_BYTE ACKed bytes.
REQ-024 On valid completion, rdata_vld SHALL pulse 1 clk after the STOP detect cycle, coincident with the rdata update.
REQ-025 Byte NUM_BYTE+1 SHALL be NACKed, rx_err SHALL pulse once, and the FSM SHALL enter WAIT_STOP.
REQ-026 STOP with fewer than NUM_BYTE bytes SHALL pulse rx_err, SHALL NOT pulse rdata_vld, and SHALL leave rdata unchanged.
REQ-027 STOP or START SHALL be honoured in any state; repeated START SHALL discard partial data and re-enter ADDR.
REQ-028 WAIT_STOP SHALL keep SDA released and return to IDLE on STOP.

Reset
REQ-029 Reset SHALL asynchronously force: FSM IDLE; rdata=0; rdata_vld=0; rx_err=0; busy=0; SDA released; counters 0.
REQ-030 Synchronizer flops SHALL reset to 1 (bus idle).
REQ-031 Reset mid-transaction SHALL release SDA immediately.
REQ-032 After reset deassertion, decoding SHALL resume at the next START only.

Configuration
REQ-033 With I2C_SLAVE_GLITCH_FILTER_EN defined, SCL and SDA SHALL each pass a 3-sample majority filter after the synchronizer, adding 2 clk of latency.
REQ-034 Without I2C_SLAVE_GLITCH_FILTER_EN, the filter SHALL be absent and the synchronizer output SHALL be used directly.

Structure
REQ-035 Package i2c_pkg SHALL hold the FSM state typedef, the BYTE_SIZE default, and the ACK/NACK constants.
REQ-036 Sub-module i2c_sync_edge SHALL contain the synchronizer, the optional filter, and the rise/fall edge detect; it is instantiated once per line.

Verification
REQ-037 Write 7'h55 with 32'hdeadbeef -> 5 ACKs observed; rdata=32'hdeadbeef; one rdata_vld pulse; rx_err stays 0.
REQ-038 Write to 7'h70 with 32'habcdabcd -> address NACKed; no rdata_vld and no rx_err; rdata unchanged.
REQ-039 Write 7'h55 with 2 bytes 8'h11, 8'h22, then STOP -> rx_err pulse; rdata unchanged.
REQ-040 Write 7'h55 with 5 bytes -> 5th byte NACKed; rx_err pulse; no rdata_vld.
REQ-041 Repeated START after 1 byte, then a full 32'h11111111 write -> rdata=32'h11111111; single rdata_vld pulse.
REQ-042 Assert rst mid-byte of 32'hcafef00d -> SDA released within 0 clk; outputs 0; next full write received correctly.

Source files
------------

// File: rtl/i2c_slave_rx_pkg.sv
// i2c_pkg: shared types and constants for the i2c_slave_rx receiver.
//   state_t        receiver FSM state encoding
//   BYTE_SIZE_DEF  default bits per data byte
//   ACK / NACK     value the slave presents on SDA in an acknowledge slot
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    WAIT_STOP
  } state_t;

  localparam int unsigned BYTE_SIZE_DEF = 8;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_slave_rx_if.sv
// i2c_slave_rx_if: receive-side result bus of the I2C write slave.
//   rdata      last complete write payload
//   rdata_vld  one-cycle pulse when rdata is updated
//   rx_err     one-cycle pulse on a malformed or overrun transaction
//   busy       high while a transaction is in progress
// Modports: slave (driven by i2c_slave_rx), master (consumer side).
interface i2c_slave_rx_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0] rdata;
  logic                  rdata_vld;
  logic                  rx_err;
  logic                  busy;

  modport slave  (output rdata, rdata_vld, rx_err, busy);
  modport master (input  rdata, rdata_vld, rx_err, busy);

endinterface

// File: rtl/i2c_slave_rx_sync_edge.sv
// i2c_sync_edge: 2-flop synchronizer for one I2C line, optional 3-sample
// majority filter, and rise/fall detection on the resulting level.
//   clk    system clock
//   rst    asynchronous active-low reset (flops reset to 1 = idle bus)
//   din    raw asynchronous line
//   level  synchronized (and filtered) line value
//   rise   one-cycle pulse on a 0->1 transition of level
//   fall   one-cycle pulse on a 1->0 transition of level
// Build option: I2C_SLAVE_GLITCH_FILTER_EN adds the majority filter
// (2 clk of extra latency).
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '1;
    else      sync_q <= {sync_q[0], din};
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [2:0] hist_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hist_q <= '1;
    else      hist_q <= {hist_q[1:0], sync_q[1]};
  end

  assign level = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) |
                 (hist_q[1] & hist_q[2]);
`else
  assign level = sync_q[1];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_q <= 1'b1;
    else      prev_q <= level;
  end

  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;

endmodule

// File: rtl/i2c_slave_rx.sv
// i2c_slave_rx: write-only I2C slave receiving NUM_BYTE bytes per transaction.
//   clk      system clock
//   rst      asynchronous active-low reset
//   i2c_SCL  bus clock from the master (no clock stretching)
//   i2c_SDA  open-drain data line, driven only low for ACK
//   rx       result bus (rdata, rdata_vld, rx_err, busy), slave modport
// Parameters: SLAVE_ADDR (7-bit), NUM_BYTE, BYTE_SIZE.
// Build option: I2C_SLAVE_GLITCH_FILTER_EN enables line majority filtering.
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = 7'h55,
  parameter int unsigned NUM_BYTE   = 4,
  parameter int unsigned BYTE_SIZE  = BYTE_SIZE_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i2c_SCL,
  inout  wire           i2c_SDA,
  i2c_slave_rx_if.slave rx
);

  localparam int unsigned DATA_WIDTH = NUM_BYTE * BYTE_SIZE;
  localparam int unsigned SH_W       = (BYTE_SIZE > 8) ? BYTE_SIZE : 8;
  localparam int unsigned BIT_W      = $clog2(SH_W + 1);
  localparam int unsigned CNT_W      = $clog2(NUM_BYTE + 1);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_sync_edge u_scl (
    .clk   (clk),
    .rst   (rst),
    .din   (i2c_SCL),
    .level (scl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_sync_edge u_sda (
    .clk   (clk),
    .rst   (rst),
    .din   (i2c_SDA),
    .level (sda),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = scl & sda_fall;
  assign stop_det  = scl & sda_rise;

  state_t                state_q, state_d;
  logic                  ack_q, ack_d;
  logic [BIT_W-1:0]      bit_cnt_q;
  logic [CNT_W-1:0]      byte_cnt_q;
  logic [SH_W-1:0]       shift_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic bit_clr, shift_en, byte_push, txn_clr, err_set, vld_set;

  // ACK is driven only while ack_q holds ACK; ack_q only changes on a
  // synchronized SCL fall (or START/STOP/reset, when it is already released).
  assign i2c_SDA = (ack_q == ACK) ? 1'b0 : 1'bz;

  always_comb begin
    state_d   = state_q;
    ack_d     = ack_q;
    bit_clr   = 1'b0;
    shift_en  = 1'b0;
    byte_push = 1'b0;
    txn_clr   = 1'b0;
    err_set   = 1'b0;
    vld_set   = 1'b0;
    if (start_det) begin
      state_d = ADDR;
      ack_d   = NACK;
      txn_clr = 1'b1;
    end else if (stop_det) begin
      state_d = IDLE;
      ack_d   = NACK;
      if ((state_q == DATA || state_q == DATA_ACK) &&
          byte_cnt_q == CNT_W'(NUM_BYTE))
        vld_set = 1'b1;
      else if (state_q != IDLE && state_q != WAIT_STOP)
        err_set = 1'b1;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: begin
          if (scl_rise && bit_cnt_q != BIT_W'(8)) begin
            shift_en = 1'b1;
          end else if (scl_fall && bit_cnt_q == BIT_W'(8)) begin
            bit_clr = 1'b1;
            if (shift_q[7:1] == SLAVE_ADDR && shift_q[0] == 1'b0) begin
              state_d = ADDR_ACK;
              ack_d   = ACK;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            state_d = DATA;
            ack_d   = NACK;
            bit_clr = 1'b1;
          end
        end
        DATA: begin
          if (scl_rise && bit_cnt_q != BIT_W'(BYTE_SIZE)) begin
            shift_en = 1'b1;
          end else if (scl_fall && bit_cnt_q == BIT_W'(BYTE_SIZE)) begin
            bit_clr = 1'b1;
            if (byte_cnt_q < CNT_W'(NUM_BYTE)) begin
              byte_push = 1'b1;
              state_d   = DATA_ACK;
              ack_d     = ACK;
            end else begin
              err_set = 1'b1;
              state_d = WAIT_STOP;
            end
          end
        end
        DATA_ACK: begin
          if (scl_fall) begin
            state_d = DATA;
            ack_d   = NACK;
          end
        end
        WAIT_STOP: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      ack_q        <= NACK;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      rx.rdata     <= '0;
      rx.rdata_vld <= 1'b0;
      rx.rx_err    <= 1'b0;
      rx.busy      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      rx.rdata_vld <= vld_set;
      rx.rx_err    <= err_set;
      rx.busy      <= (state_d != IDLE);
      if (vld_set) rx.rdata <= data_q;

      if (txn_clr || bit_clr) begin
        bit_cnt_q <= '0;
      end else if (shift_en) begin
        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
        shift_q   <= {shift_q[SH_W-2:0], sda};
      end

      // Bytes enter at the bottom and move up, so the first byte ends in the MSBs.
      if (txn_clr) begin
        byte_cnt_q <= '0;
        data_q     <= '0;
      end else if (byte_push) begin
        byte_cnt_q <= byte_cnt_q + CNT_W'(1);
        data_q     <= (data_q << BYTE_SIZE) | DATA_WIDTH'(shift_q[BYTE_SIZE-1:0]);
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_rx.sv
module tb_i2c_slave_rx;

  localparam int Q = 6;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic scl   = 1'b1;
  logic m_sda = 1'b1;
  wire  sda;

  pullup (sda);
  assign sda = m_sda ? 1'bz : 1'b0;

  always #5 clk = ~clk;

  i2c_slave_rx_if #(.DATA_WIDTH(32)) rx ();

  i2c_slave_rx #(
    .SLAVE_ADDR (7'h55),
    .NUM_BYTE   (4),
    .BYTE_SIZE  (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i2c_SCL (scl),
    .i2c_SDA (sda),
    .rx      (rx)
  );

  int checks   = 0;
  int failures = 0;
  int vld_cnt  = 0;
  int err_cnt  = 0;

  always @(negedge clk) begin
    if (rx.rdata_vld) vld_cnt++;
    if (rx.rx_err)    err_cnt++;
  end

  typedef struct {
    logic [6:0]  addr;
    logic        rw;
    int          nbytes;
    logic [39:0] payload;
    int          exp_acks;
    int          exp_vld;
    int          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic start_cond();
    wq(); m_sda = 1'b1;
    wq(); scl = 1'b1;
    wq(); m_sda = 1'b0;
    wq(); scl = 1'b0;
  endtask

  task automatic stop_cond();
    wq(); m_sda = 1'b0;
    wq(); scl = 1'b1;
    wq(); m_sda = 1'b1;
    wq();
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      wq(); m_sda = b[i];
      wq(); scl = 1'b1;
      wq(); wq(); scl = 1'b0;
    end
  endtask

  task automatic ack_slot(output logic got_ack);
    wq(); m_sda = 1'b1;
    wq(); scl = 1'b1;
    wq(); got_ack = (sda === 1'b0);
    wq(); scl = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, output int acks);
    logic a;
    acks = 0;
    start_cond();
    send_byte({v.addr, v.rw});
    ack_slot(a);
    if (a) begin
      acks++;
      for (int i = 0; i < v.nbytes; i++) begin
        send_byte(v.payload[39-8*i -: 8]);
        ack_slot(a);
        if (a) acks++;
      end
    end
    stop_cond();
    repeat (4) @(negedge clk);
  endtask

  vec_t vecs[6];

  initial begin
    int   acks, v0, e0;
    logic a;

    vecs[0] = '{7'h55, 1'b0, 4, 40'hdeadbeef00, 5, 1, 0, 32'hdeadbeef};
    vecs[1] = '{7'h70, 1'b0, 4, 40'habcdabcd00, 0, 0, 0, 32'hdeadbeef};
    vecs[2] = '{7'h55, 1'b1, 4, 40'h1234567800, 0, 0, 0, 32'hdeadbeef};
    vecs[3] = '{7'h55, 1'b0, 2, 40'h1122000000, 3, 0, 1, 32'hdeadbeef};
    vecs[4] = '{7'h55, 1'b0, 5, 40'h0102030405, 5, 0, 1, 32'hdeadbeef};
    vecs[5] = '{7'h55, 1'b0, 4, 40'h0a0b0c0d00, 5, 1, 0, 32'h0a0b0c0d};

    repeat (3) @(negedge clk);
    check("rst_rdata", rx.rdata, 0);
    check("rst_vld", rx.rdata_vld, 0);
    check("rst_err", rx.rx_err, 0);
    check("rst_busy", rx.busy, 0);
    check("rst_sda", sda, 1);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      v0 = vld_cnt;
      e0 = err_cnt;
      run_vec(vecs[i], acks);
      check($sformatf("v%0d_acks", i), acks, vecs[i].exp_acks);
      check($sformatf("v%0d_vld", i), vld_cnt - v0, vecs[i].exp_vld);
      check($sformatf("v%0d_err", i), err_cnt - e0, vecs[i].exp_err);
      check($sformatf("v%0d_rdata", i), rx.rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_busy", i), rx.busy, 0);
    end

    // Repeated START after one byte discards it; the following write completes.
    v0 = vld_cnt;
    e0 = err_cnt;
    start_cond();
    send_byte(8'haa); ack_slot(a);
    check("rs_addr_ack", a, 1);
    send_byte(8'h99); ack_slot(a);
    check("rs_byte_ack", a, 1);
    start_cond();
    send_byte(8'haa); ack_slot(a);
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h11); ack_slot(a);
    end
    stop_cond();
    repeat (4) @(negedge clk);
    check("rs_rdata", rx.rdata, 32'h11111111);
    check("rs_vld", vld_cnt - v0, 1);
    check("rs_err", err_cnt - e0, 0);

    // Reset while the slave is holding SDA low for the first data byte's ACK.
    start_cond();
    send_byte(8'haa); ack_slot(a);
    send_byte(8'hca);
    wq(); m_sda = 1'b1;
    wq(); scl = 1'b1;
    wq();
    check("mid_ack_driven", sda, 0);
    check("mid_busy", rx.busy, 1);
    rst = 1'b0;
    #1;
    check("rst_sda_released", sda, 1);
    check("rst_rdata_clr", rx.rdata, 0);
    check("rst_busy_clr", rx.busy, 0);
    check("rst_vld_clr", rx.rdata_vld, 0);
    check("rst_err_clr", rx.rx_err, 0);
    wq();
    rst = 1'b1;
    wq();
    v0 = vld_cnt;
    e0 = err_cnt;
    run_vec('{7'h55, 1'b0, 4, 40'hcafef00d00, 5, 1, 0, 32'hcafef00d}, acks);
    check("post_rst_acks", acks, 5);
    check("post_rst_rdata", rx.rdata, 32'hcafef00d);
    check("post_rst_vld", vld_cnt - v0, 1);
    check("post_rst_err", err_cnt - e0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
